sqrt_result_bcd: RTL and testbench

//   Downstream of the Squareroot stage. Takes its free-running binary result,

---
 rtl/calc_pkg.sv | 27 ++
 rtl/bcd_add3.sv | 16 +
 rtl/sqrt_result_bcd.sv | 98 +++++++++
 tb/tb_sqrt_result_bcd.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and helpers for the calculator result path.
package calc_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    // Smallest digit count whose decimal range covers every width-bit value.
    function automatic int unsigned digits_for(input int unsigned width);
        longint unsigned lim;
        longint unsigned p;
        int unsigned     d;
        lim = 64'(1) << width;
        p   = 64'(10);
        d   = 1;
        while (p < lim) begin
            p = p * 64'(10);
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_add3
    import calc_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q_c
);

    always_comb begin
        q_c = d;
        if (d >= BCD_W'(5)) begin
            q_c = d + BCD_W'(3);
        end
    end

endmodule

// File: rtl/sqrt_result_bcd.sv
// Converts the free-running Squareroot result to packed BCD whenever it changes
// and offers it to the display driver over valid/ready, keeping the last value.
module sqrt_result_bcd
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    output logic [BCD_W*DIGITS-1:0]   out_bcd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int unsigned BCD_TOTAL = BCD_W * DIGITS;
    localparam int unsigned CNT_W     = $clog2(WIDTH + 1);

    generate
        if (DIGITS < digits_for(WIDTH)) begin : g_bad_digits
            $error("sqrt_result_bcd: DIGITS too small to hold 2**WIDTH-1");
        end
    endgenerate

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [WIDTH-1:0]       shift_q;
    logic [WIDTH-1:0]       last_val;
    logic                   primed;
    logic [BCD_TOTAL-1:0]   scratch;
    logic [BCD_TOTAL-1:0]   adj_c;
    logic [BCD_TOTAL-1:0]   scratch_nxt_c;
    logic [WIDTH-1:0]       shift_nxt_c;

    generate
        for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
            bcd_add3 u_add3 (
                .d   (scratch[g*BCD_W +: BCD_W]),
                .q_c (adj_c[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // One shift-add-3 step: corrected scratch and binary shift left as one word.
    assign {scratch_nxt_c, shift_nxt_c} = {adj_c, shift_q} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shift_q   <= '0;
            last_val  <= '0;
            primed    <= 1'b0;
            scratch   <= '0;
            out_bcd   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!primed || (in_data != last_val)) begin
                        shift_q  <= in_data;
                        last_val <= in_data;
                        primed   <= 1'b1;
                        cnt      <= CNT_W'(WIDTH);
                        scratch  <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    scratch <= scratch_nxt_c;
                    shift_q <= shift_nxt_c;
                    cnt     <= cnt - CNT_W'(1);
                    // Last step: publish straight from the combinational result.
                    if (cnt == CNT_W'(1)) begin
                        out_bcd   <= scratch_nxt_c;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_result_bcd.sv
// Bench for sqrt_result_bcd: fixed vectors, corner sequences and random values
// against a decimal-arithmetic reference.
module tb_sqrt_result_bcd;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [11:0] out_bcd;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks;
    int failures;

    sqrt_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, independent of shift-add-3.
    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Counts posedges until out_valid is seen; n=-1 on timeout.
    task automatic wait_valid(input logic [7:0] v, input bit wiggle, output int n, output int nb);
        n  = 0;
        nb = 0;
        forever begin
            if (n >= 40) begin
                n = -1;
                return;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy) nb++;
            if (wiggle) begin
                if (n >= 1 && n <= 6) in_data = 8'($urandom);
                else if (n == 7)      in_data = v;
            end
            if (out_valid) return;
        end
    endtask

    task automatic handshake(input string name, input bit expect_idle);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_drop"}, 32'(out_valid), 32'd0);
        if (expect_idle) begin
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
            end
            check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
            check({name, "_idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic convert(input string name, input logic [7:0] v, input logic [11:0] exp, input bit wiggle);
        int n, nb;
        in_data = v;
        wait_valid(v, wiggle, n, nb);
        check({name, "_lat"}, 32'(n), 32'd9);
        check({name, "_busy"}, 32'(nb), 32'd9);
        check({name, "_bcd"}, 32'(out_bcd), 32'(exp));
    endtask

    // Protocol watch: valid must not drop and data must not move without a handshake.
    bit          pv, pr;
    logic [11:0] pb;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_bcd", 32'(out_bcd), 32'(pb));
            end
            pv = out_valid;
            pr = out_ready;
            pb = out_bcd;
        end
    end

    initial begin
        int          n, nb, pulses;
        logic [7:0]  v, prev;

        checks   = 0;
        failures = 0;
        tbl[0] = '{8'd2,   12'h002};
        tbl[1] = '{8'd255, 12'h255};
        tbl[2] = '{8'd99,  12'h099};
        tbl[3] = '{8'd100, 12'h100};
        tbl[4] = '{8'd1,   12'h001};
        tbl[5] = '{8'd9,   12'h009};
        tbl[6] = '{8'd10,  12'h010};
        tbl[7] = '{8'd128, 12'h128};

        // Reset with zero input: zero converts once, then nothing more.
        rst_n     = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(out_bcd), 32'd0);
        rst_n = 1'b1;
        wait_valid(8'd0, 1'b0, n, nb);
        check("zero_lat", 32'(n), 32'd9);
        check("zero_bcd", 32'(out_bcd), 32'h000);
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("zero_pulses", 32'(pulses), 32'd0);
        out_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            convert($sformatf("tbl%0d", i), tbl[i].din, tbl[i].exp, 1'b0);
            handshake($sformatf("tbl%0d", i), 1'b1);
        end

        // Back-pressure: result held, new input waits for the handshake.
        convert("bp50", 8'd50, 12'h050, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) in_data = 8'd15;
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_bcd", 32'(out_bcd), 32'h050);
        handshake("bp", 1'b0);
        wait_valid(8'd15, 1'b0, n, nb);
        check("bp15_lat", 32'(n), 32'd9);
        check("bp15_bcd", 32'(out_bcd), 32'h015);
        handshake("bp15", 1'b1);

        // Changes mid-conversion: 10 converts, 11 is dropped, 12 follows.
        in_data = 8'd10;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_data = 8'd11;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_data = 8'd12;
        wait_valid(8'd12, 1'b0, n, nb);
        check("mid10_lat", 32'(n), 32'd4);
        check("mid10_bcd", 32'(out_bcd), 32'h010);
        handshake("mid10", 1'b0);
        wait_valid(8'd12, 1'b0, n, nb);
        check("mid12_lat", 32'(n), 32'd9);
        check("mid12_bcd", 32'(out_bcd), 32'h012);
        handshake("mid12", 1'b1);

        // Reset in the middle of converting 200.
        in_data = 8'd200;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mrst_bcd", 32'(out_bcd), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(8'd200, 1'b0, n, nb);
        check("mrst200_lat", 32'(n), 32'd9);
        check("mrst200_bcd", 32'(out_bcd), 32'h200);
        handshake("mrst200", 1'b1);

        // Random values with input noise during conversion and random back-pressure.
        prev = 8'd200;
        for (int i = 0; i < 40; i++) begin
            do v = 8'($urandom_range(0, 255)); while (v == prev);
            convert($sformatf("rnd%0d", i), v, to_bcd(int'(v)), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                @(negedge clk);
            end
            check($sformatf("rnd%0d_held", i), 32'(out_bcd), 32'(to_bcd(int'(v))));
            handshake($sformatf("rnd%0d", i), (i % 4) == 0);
            prev = v;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
